multicycle_controller: RTL

Multi-cycle sequencer for the MIPS-subset CPU. It steps the shared datapath (one ALU, one unified memory port, register file, PC and IR) through FETCH/DECODE/EXEC/MEM/WB states. It emits per-cycle enables and mux selects from the IR's `opcode`/`funct`, the ALU `zero` flag and a memory-ready handshake. The supported set is ADD, SUB, SLT, JR, J, JAL, ADDI, XORI, BEQ, BNE, LW and SW. ALU op codes match the existing decoder: ADD=0, SUB=1, XOR=2, SLT=3.

---
 rtl/multicycle_controller.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset multi-cycle datapath.
// Build option MC_ILLEGAL_TRAP_EN: unsupported instructions halt the core and raise a sticky illegal flag.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_we,
  output logic       mem_re,
  output logic       iord,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic [1:0] pc_src,
  output logic [2:0] state,
  output logic       retired,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  state_e state_q;
  state_e state_d;

  logic is_rtype_s, is_alu_r_s, is_jr_s, is_j_s, is_jal_s, is_beq_s, is_bne_s;
  logic is_addi_s, is_xori_s, is_lw_s, is_sw_s, supported_s;

  logic       pc_we_s, ir_we_s, reg_we_s, mem_we_s, mem_re_s, iord_s, alu_src_a_s, retired_s;
  logic [2:0] alu_op_s, alu_src_b_s;
  logic [1:0] reg_dst_s, wb_sel_s, pc_src_s;

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q;
  logic illegal_d;
`endif

  assign is_rtype_s  = (opcode == OP_RTYPE);
  assign is_alu_r_s  = is_rtype_s && ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT));
  assign is_jr_s     = is_rtype_s && (funct == FN_JR);
  assign is_j_s      = (opcode == OP_J);
  assign is_jal_s    = (opcode == OP_JAL);
  assign is_beq_s    = (opcode == OP_BEQ);
  assign is_bne_s    = (opcode == OP_BNE);
  assign is_addi_s   = (opcode == OP_ADDI);
  assign is_xori_s   = (opcode == OP_XORI);
  assign is_lw_s     = (opcode == OP_LW);
  assign is_sw_s     = (opcode == OP_SW);
  assign supported_s = is_alu_r_s | is_jr_s | is_j_s | is_jal_s | is_beq_s | is_bne_s
                     | is_addi_s | is_xori_s | is_lw_s | is_sw_s;

  // State decode: next state and raw per-cycle controls before the reset override
  always_comb begin
    state_d     = state_q;
    pc_we_s     = 1'b0;
    ir_we_s     = 1'b0;
    reg_we_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_re_s    = 1'b0;
    iord_s      = 1'b0;
    alu_op_s    = 3'd0;
    alu_src_a_s = 1'b0;
    alu_src_b_s = 3'd0;
    reg_dst_s   = 2'd0;
    wb_sel_s    = 2'd0;
    pc_src_s    = 2'd0;
    retired_s   = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal_d   = illegal_q;
`endif
    case (state_q)
      S_FETCH: begin
        mem_re_s    = 1'b1;
        alu_src_b_s = 3'd1;
        if (mem_ready) begin
          ir_we_s = 1'b1;
          pc_we_s = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target is computed here so EXEC only needs the compare
        alu_src_b_s = 3'd4;
        if (is_j_s || is_jal_s) begin
          pc_we_s   = 1'b1;
          pc_src_s  = 2'd2;
          retired_s = 1'b1;
          state_d   = S_FETCH;
          if (is_jal_s) begin
            reg_we_s  = 1'b1;
            reg_dst_s = 2'd2;
            wb_sel_s  = 2'd2;
          end else begin
            reg_we_s  = 1'b0;
          end
        end else if (is_jr_s) begin
          pc_we_s   = 1'b1;
          pc_src_s  = 2'd3;
          retired_s = 1'b1;
          state_d   = S_FETCH;
        end else if (supported_s) begin
          state_d = S_EXEC;
        end else begin
`ifdef MC_ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = S_HALT;
`else
          retired_s = 1'b1;
          state_d   = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        alu_src_a_s = 1'b1;
        if (is_alu_r_s) begin
          alu_src_b_s = 3'd0;
          case (funct)
            FN_SUB:  alu_op_s = 3'd1;
            FN_SLT:  alu_op_s = 3'd3;
            default: alu_op_s = 3'd0;
          endcase
          state_d = S_WB;
        end else if (is_addi_s) begin
          alu_src_b_s = 3'd2;
          state_d     = S_WB;
        end else if (is_xori_s) begin
          alu_src_b_s = 3'd3;
          alu_op_s    = 3'd2;
          state_d     = S_WB;
        end else if (is_lw_s || is_sw_s) begin
          alu_src_b_s = 3'd2;
          state_d     = S_MEM;
        end else if (is_beq_s || is_bne_s) begin
          alu_src_b_s = 3'd0;
          alu_op_s    = 3'd1;
          pc_src_s    = 2'd1;
          pc_we_s     = is_beq_s ? zero : ~zero;
          retired_s   = 1'b1;
          state_d     = S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        iord_s = 1'b1;
        if (is_lw_s) begin
          mem_re_s = 1'b1;
          state_d  = mem_ready ? S_WB : S_MEM;
        end else if (is_sw_s) begin
          mem_we_s  = 1'b1;
          retired_s = mem_ready;
          state_d   = mem_ready ? S_FETCH : S_MEM;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        reg_we_s  = 1'b1;
        reg_dst_s = is_rtype_s ? 2'd1 : 2'd0;
        wb_sel_s  = is_lw_s ? 2'd1 : 2'd0;
        retired_s = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State register with synchronous reset back to FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Reset masks every output in the same cycle so an abandoned instruction writes nothing
  assign pc_we     = pc_we_s     & ~reset;
  assign ir_we     = ir_we_s     & ~reset;
  assign reg_we    = reg_we_s    & ~reset;
  assign mem_we    = mem_we_s    & ~reset;
  assign mem_re    = mem_re_s    & ~reset;
  assign iord      = iord_s      & ~reset;
  assign alu_src_a = alu_src_a_s & ~reset;
  assign retired   = retired_s   & ~reset;
  assign alu_op    = reset ? 3'd0 : alu_op_s;
  assign alu_src_b = reset ? 3'd0 : alu_src_b_s;
  assign reg_dst   = reset ? 2'd0 : reg_dst_s;
  assign wb_sel    = reset ? 2'd0 : wb_sel_s;
  assign pc_src    = reset ? 2'd0 : pc_src_s;
  assign state     = reset ? 3'd0 : state_q;
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal   = illegal_q & ~reset;
`else
  assign illegal   = 1'b0;
`endif

endmodule
